fifo_rd_stream: RTL and testbench
=================================

# fifo_rd_stream

Read-side drain engine for `sync_fifo`. Pops words from the FIFO's registered read port, with its one-cycle read latency, and presents them as a valid/ready stream to a downstream consumer. A 3-entry output buffer sustains one word per cycle while keeping `fifo_rd_en` free of any combinational dependence on `m_ready`. Sits directly on the `dout`/`empty`/`rd_en` side of `sync_fifo`, mirroring the writer that drives `din`/`wr_en`.

## Interface
- `DWIDTH`, 16: data width; must equal `sync_fifo` `DWIDTH`.
- `CWIDTH`, 16: width of the delivered-word counter.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous reset, active-high, sampled on `clk` rising edge.
- `fifo_empty`  in  1: `sync_fifo` `empty`.
- `fifo_dout`  in  DWIDTH: `sync_fifo` `dout`; valid in the cycle after a cycle with `fifo_rd_en`=1.
- `fifo_rd_en`  out  1: pop request to `sync_fifo` `rd_en`.
- `flush`  in  1: synchronous discard of all buffered and in-flight words.
- `m_valid`  out  1: stream data valid.
- `m_ready`  in  1: consumer accepts the word when `m_valid` and `m_ready` are both 1.
- `m_data`  out  DWIDTH: stream data (buffer head).
- `m_count`  out  CWIDTH: number of completed handshakes since reset; wraps modulo 2^CWIDTH.

## Operation
- State:
  - `occ`, 0..3: buffer occupancy.
  - `infl`, 0/1: a read was issued last cycle and its data lands this cycle.
  - A 3-entry circular buffer with wrapping 2-bit read/write pointers (0→1→2→0).
- Issue rule: `fifo_rd_en` = !rst & !flush & !fifo_empty & (occ + infl < 3). It is a function of registered state plus `fifo_empty`/`flush`/`rst` only, never of `m_ready`.
- `infl` next = `fifo_rd_en`.
- Capture: when `infl`=1 and not flushing, write `fifo_dout` at the write pointer, then advance the pointer.
- Output: `m_valid` = (occ != 0); `m_data` = entry at the read pointer. A handshake advances the read pointer and increments `m_count`.
- Occupancy update in the same cycle: occ next = occ + capture − handshake. Capture and handshake together leave `occ` unchanged. The credit rule guarantees no overflow.
- Ordering: words leave in exact FIFO pop order; no drops or duplicates except on flush/reset.
- Flush:
  - In the flush cycle, `fifo_rd_en`=0, `occ`→0 and pointers→0.
  - A word arriving that cycle (`infl`=1) is discarded.
  - `infl`→0.
  - `m_valid` may still be 1 during the flush cycle. A handshake in that cycle counts in `m_count`, but the word is not replayed.
  - `m_count` is not cleared by flush.
- Reset: identical to flush, plus `m_count`→0. A reset asserted mid-stream drops everything buffered or in flight; the FIFO's own contents are untouched.
- Never pops an empty FIFO, because `fifo_empty` gates `fifo_rd_en`.

## Timing
- Output values during/after reset: `fifo_rd_en`=0, `m_valid`=0, `m_data`=0 (buffer cleared), `m_count`=0.
- First-word latency: `fifo_rd_en`=1 in cycle k → data captured at the end of cycle k+1 → `m_valid`=1 in cycle k+2.
- Throughput: with `m_ready` held at 1 and the FIFO non-empty, one word per cycle indefinitely after the 2-cycle fill.
- Backpressure: with `m_ready`=0, at most 3 pops occur after the stall starts; then `fifo_rd_en` stays 0.
- Stall rule: while `m_valid`=1 and `m_ready`=0, `m_data` and `m_valid` hold stable.
- Empty boundary: when `fifo_empty` rises, `fifo_rd_en` drops in the same cycle. Buffered words continue to drain.
- `m_count` wraps from 2^CWIDTH−1 to 0 with no flag.

## Test plan
- Reset, then preload FIFO with 8 words (0x1111..0x8888), `m_ready`=1 → `fifo_rd_en` high for 8 consecutive cycles; `m_valid` high for 8 consecutive cycles starting 2 cycles later; data in order; `m_count`=8.
- Preload 8 words, `m_ready`=0 for 10 cycles, then 1 → exactly 3 pops, `m_data`=first word stable throughout the stall; then all 8 words delivered in order with no gaps.
- Concurrent writer at random rate with `m_ready` toggling pseudo-randomly for 200 words → scoreboard matches bit-exactly; `fifo_rd_en` never asserted while `fifo_empty`=1; `occ` never exceeds 3.
- Assert `flush` for 1 cycle with `occ`=2 and `infl`=1 → next cycle `m_valid`=0; the 3 discarded words never appear; next output is the following FIFO word; `m_count` unchanged except for a handshake in the flush cycle.
- Assert `rst` mid-stream at `m_count`=5 → next cycle `m_valid`=0, `m_count`=0, `fifo_rd_en`=0 during reset; after release, resumes from the current FIFO head.
- Set CWIDTH=4, deliver 17 words → `m_count` reads 1.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Read-side drain engine for sync_fifo: pops words across the FIFO's one-cycle read
// latency and re-presents them as a valid/ready stream through a 3-entry buffer.
module fifo_rd_stream #(
    parameter int DWIDTH = 16,
    parameter int CWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_dout,
    output logic              fifo_rd_en,
    input  logic              flush,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic [CWIDTH-1:0] m_count
);

    logic [1:0]        occ;
    logic [1:0]        occ_nxt;
    logic              infl;
    logic [1:0]        rd_ptr;
    logic [1:0]        wr_ptr;
    logic [DWIDTH-1:0] buf_q [3];
    logic              capture;
    logic              handshake;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Credit counts the in-flight word as well, so a pop never lands in a full buffer;
    // m_ready is deliberately absent to keep rd_en off the consumer's combinational path.
    assign fifo_rd_en = !rst && !flush && !fifo_empty &&
                        (({1'b0, occ} + {2'b00, infl}) < 3'd3);

    assign capture   = infl && !flush;
    assign handshake = m_valid && m_ready;
    assign m_valid   = (occ != 2'd0);
    assign m_data    = buf_q[rd_ptr];

    always_comb begin
        occ_nxt = occ;
        if (capture && !handshake) begin
            occ_nxt = occ + 2'd1;
        end else if (!capture && handshake) begin
            occ_nxt = occ - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ     <= 2'd0;
            infl    <= 1'b0;
            rd_ptr  <= 2'd0;
            wr_ptr  <= 2'd0;
            m_count <= '0;
            // NOTE: the buffer is reset (not just the pointers) so m_data reads 0 after reset.
            for (int i = 0; i < 3; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking throughout so every branch sees the pre-edge state.
            infl <= fifo_rd_en;
            if (handshake) begin
                m_count <= m_count + CWIDTH'(1);
            end
            if (flush) begin
                occ    <= 2'd0;
                rd_ptr <= 2'd0;
                wr_ptr <= 2'd0;
            end else begin
                occ <= occ_nxt;
                if (capture) begin
                    buf_q[wr_ptr] <= fifo_dout;
                    wr_ptr        <= ptr_inc(wr_ptr);
                end
                if (handshake) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized self-checking bench for fifo_rd_stream: a queue-based sync_fifo model feeds
// the DUT and a scoreboard of popped-but-undelivered words predicts the stream.
module tb_fifo_rd_stream;

    localparam int DW = 16;

    typedef struct {
        logic [DW-1:0] data;
        int            avail;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          m_ready = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_rd_en, fifo_rd_en4;
    logic          m_valid, m_valid4;
    logic [DW-1:0] m_data, m_data4;
    logic [15:0]   m_count;
    logic [3:0]    m_count4;

    logic [DW-1:0] fq[$];
    ent_t          pipe[$];
    int            cyc = 0;
    int            model_cnt = 0;
    int            n_pops = 0;
    int            n_deliv = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    logic          wr_req = 1'b0;
    logic [DW-1:0] wdata = 16'h4000;

    always #5 clk = ~clk;

    fifo_rd_stream #(.DWIDTH(DW), .CWIDTH(16)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_count(m_count)
    );

    fifo_rd_stream #(.DWIDTH(DW), .CWIDTH(4)) dut_w4 (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en4), .flush(flush), .m_valid(m_valid4), .m_ready(m_ready),
        .m_data(m_data4), .m_count(m_count4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: inputs are already set (just after a falling edge); checks outputs,
    // advances the scoreboard, then models the FIFO's registered read port.
    task automatic cycle();
        logic exp_rd, exp_valid, hs, rd_s;
        #1;
        exp_rd    = !rst && !flush && !fifo_empty && (pipe.size() < 3);
        exp_valid = (pipe.size() > 0) && (pipe[0].avail <= cyc);
        check("rd_en", 32'(fifo_rd_en), 32'(exp_rd));
        check("m_valid", 32'(m_valid), 32'(exp_valid));
        if (exp_valid) check("m_data", 32'(m_data), 32'(pipe[0].data));
        check("m_count", 32'(m_count), 32'(model_cnt[15:0]));
        check("w4_rd_en", 32'(fifo_rd_en4), 32'(exp_rd));
        check("w4_m_valid", 32'(m_valid4), 32'(exp_valid));
        if (exp_valid) check("w4_m_data", 32'(m_data4), 32'(pipe[0].data));
        check("w4_m_count", 32'(m_count4), 32'(model_cnt[3:0]));
        rd_s = fifo_rd_en;
        if (rd_s) n_pops++;
        hs = exp_valid && m_ready;
        if (rst) begin
            pipe.delete();
            model_cnt = 0;
        end else begin
            if (hs) begin
                void'(pipe.pop_front());
                model_cnt++;
                n_deliv++;
            end
            if (flush) pipe.delete();
            else if (exp_rd && fq.size() > 0) pipe.push_back('{fq[0], cyc + 2});
        end
        @(posedge clk);
        #1;
        if (rd_s && fq.size() > 0) fifo_dout = fq.pop_front();
        if (wr_req && fq.size() < 16) begin
            fq.push_back(wdata);
            wdata = wdata + 16'd1;
        end
        fifo_empty = (fq.size() == 0);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic preload(input int n, input logic [DW-1:0] base, input logic [DW-1:0] step);
        logic [DW-1:0] v;
        v = base;
        for (int i = 0; i < n; i++) begin
            fq.push_back(v);
            v = v + step;
        end
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        check("post_rst_m_data", 32'(m_data), 32'h0);
        check("post_rst_m_valid", 32'(m_valid), 32'h0);
        check("post_rst_m_count", 32'(m_count), 32'h0);
    endtask

    initial begin
        int guard;
        repeat (2) @(posedge clk);
        @(negedge clk);
        do_reset();

        // Preloaded burst, consumer always ready.
        m_ready = 1'b1;
        n_pops  = 0;
        preload(8, 16'h1111, 16'h1111);
        run(12);
        check("burst_pops", n_pops, 8);
        check("burst_count", 32'(m_count), 8);

        // Stall for 10 cycles: only the 3 credits are spent.
        m_ready = 1'b0;
        n_pops  = 0;
        preload(8, 16'h2000, 16'h0001);
        run(10);
        check("stall_pops", n_pops, 3);
        check("stall_head", 32'(m_data), 32'h2000);
        m_ready = 1'b1;
        run(12);
        check("stall_count", 32'(m_count), 16);

        // Flush with two buffered words and one in flight.
        m_ready = 1'b0;
        preload(8, 16'hA001, 16'h0001);
        run(3);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        #1;
        check("flush_m_valid", 32'(m_valid), 32'h0);
        m_ready = 1'b1;
        run(10);
        check("flush_count", 32'(m_count), 21);

        // Reset mid-stream once five words have been delivered.
        do_reset();
        preload(8, 16'hB001, 16'h0001);
        guard = 0;
        while (model_cnt != 5 && guard < 30) begin
            cycle();
            guard++;
        end
        check("reach_count5", model_cnt, 5);
        do_reset();
        run(12);
        check("rst_fifo_drained", fq.size(), 0);

        // Counter wrap on the 4-bit instance.
        do_reset();
        preload(17, 16'hC000, 16'h0001);
        run(22);
        check("wrap_w4", 32'(m_count4), 32'h1);
        check("wrap_w16", 32'(m_count), 32'd17);

        // Concurrent writer, random consumer, occasional flush.
        n_deliv = 0;
        guard   = 0;
        while (n_deliv < 200 && guard < 4000) begin
            wr_req  = ($urandom_range(0, 2) != 0);
            m_ready = ($urandom_range(0, 1) != 0);
            flush   = ($urandom_range(0, 63) == 0);
            cycle();
            guard++;
        end
        wr_req = 1'b0;
        flush  = 1'b0;
        check("rand_delivered", 32'(n_deliv >= 200), 32'h1);
        m_ready = 1'b1;
        run(40);
        check("rand_drained", pipe.size() + fq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
